ppu_line_mixer: RTL and testbench

PPU_LINE_MIXER -- requirements
Module: ppu_line_mixer

---
 rtl/ppu_line_mixer.sv | 213 +++++++++++++++++++++
 tb/tb_ppu_line_mixer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_mixer.sv
// ppu_line_mixer
//   Double-buffered scanline mixer between the PPU line assembler and the
//   VGA output. The assembler fills the write bank while the display bank
//   is scanned out. The banks swap at hcount == 0 once the assembler has
//   signalled line_done. Each pixel looks up a palette entry and drives rgb
//   two cycles after its hcount is presented.
//
//   Optional feature macro: PPU_MIX_SPRITE_EN
//     defined   - a per-pixel sprite layer is stored and overlaid on the
//                 background. Sprite index 0 is transparent.
//     undefined - sprite storage is omitted, spr_* inputs are ignored, and
//                 only the background colour is output.
//
// Parameters
//   LINE_W   visible pixels per line (default 640)
//   IDX_W    palette index width (default 3, giving 8 entries)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   hcount     in   VGA horizontal counter; pixel x = hcount[10:1]
//   vblank     in   high during vertical blanking
//   bg_we      in   background pixel write strobe
//   bg_x       in   background pixel x
//   bg_idx     in   background palette index
//   spr_we     in   sprite pixel write strobe
//   spr_x      in   sprite pixel x
//   spr_idx    in   sprite palette index
//   line_done  in   one-cycle pulse: the write bank is complete
//   pal_we     in   palette register write strobe
//   pal_addr   in   palette register address
//   pal_data   in   palette colour {R,G,B}
//   rgb        out  pixel colour {R,G,B}
//   underrun   out  sticky: a line swap found no completed line
module ppu_line_mixer #(
    parameter int unsigned LINE_W = 640,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic              vblank,
    input  logic              bg_we,
    input  logic [9:0]        bg_x,
    input  logic [IDX_W-1:0]  bg_idx,
    input  logic              spr_we,
    input  logic [9:0]        spr_x,
    input  logic [IDX_W-1:0]  spr_idx,
    input  logic              line_done,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [23:0]       pal_data,
    output logic [23:0]       rgb,
    output logic              underrun
);

    localparam int unsigned AW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned PAL_N = 1 << IDX_W;

    // ------------------------------------------------------------------
    // Bank control
    // ------------------------------------------------------------------
    logic          display_bank;
    logic          wr_bank;
    logic          pending;
    logic          line_start;
    logic          swap;
    logic [9:0]    pix_x;
    logic          pix_in_line;
    logic          bg_ok;
    logic [AW-1:0] bg_addr;

    assign wr_bank     = ~display_bank;
    assign line_start  = (hcount == '0);
    assign swap        = line_start & pending;
    assign pix_x       = hcount[10:1];
    assign pix_in_line = (32'(pix_x) < LINE_W);
    assign bg_ok       = bg_we & ~reset & (32'(bg_x) < LINE_W);
    assign bg_addr     = bg_x[AW-1:0];

    // A line_done arriving in the swap cycle belongs to the next line, so
    // it re-arms pending rather than being consumed by this swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_bank <= 1'b0;
            pending      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (swap) begin
                display_bank <= ~display_bank;
                pending      <= line_done;
            end else if (line_done) begin
                pending <= 1'b1;
            end
            if (line_start && !pending && !vblank) begin
                underrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Background line banks (contents are not reset)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] bg_mem [2][LINE_W];

    // wr_bank is taken from the registered display_bank, so a write in the
    // swap cycle still lands in the pre-swap write bank.
    always_ff @(posedge clk) begin
        if (bg_ok) begin
            bg_mem[wr_bank][bg_addr] <= bg_idx;
        end
    end

    // ------------------------------------------------------------------
    // Sprite layer
    // ------------------------------------------------------------------
    logic [AW-1:0]    rd_addr;
    logic [IDX_W-1:0] sel_idx;

    assign rd_addr = pix_in_line ? pix_x[AW-1:0] : '0;

`ifdef PPU_MIX_SPRITE_EN
    logic [LINE_W-1:0] spr_valid [2];
    logic [IDX_W-1:0]  spr_mem   [2][LINE_W];
    logic              spr_ok;
    logic [AW-1:0]     spr_addr;

    assign spr_ok   = spr_we & ~reset & (32'(spr_x) < LINE_W);
    assign spr_addr = spr_x[AW-1:0];

    // On a swap the outgoing display bank becomes the new write bank and
    // starts with no sprites. Writes in that cycle target the other bank,
    // so the clear and the write never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            spr_valid[0] <= '0;
            spr_valid[1] <= '0;
        end else begin
            if (swap) begin
                spr_valid[display_bank] <= '0;
            end
            if (spr_ok) begin
                spr_valid[wr_bank][spr_addr] <= (spr_idx != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (spr_ok) begin
            spr_mem[wr_bank][spr_addr] <= spr_idx;
        end
    end

    always_comb begin
        sel_idx = bg_mem[display_bank][rd_addr];
        if (spr_valid[display_bank][rd_addr]) begin
            sel_idx = spr_mem[display_bank][rd_addr];
        end
    end

    logic unused_bits;
    assign unused_bits = hcount[0];
`else
    always_comb begin
        sel_idx = bg_mem[display_bank][rd_addr];
    end

    logic unused_bits;
    assign unused_bits = ^{hcount[0], spr_we, spr_x, spr_idx};
`endif

    // ------------------------------------------------------------------
    // Pipeline stage 1: capture the pixel index and its visibility
    // ------------------------------------------------------------------
    logic             vis_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vis_q <= 1'b0;
            idx_q <= '0;
        end else begin
            vis_q <= ~vblank & pix_in_line;
            idx_q <= sel_idx;
        end
    end

    // ------------------------------------------------------------------
    // Palette and pipeline stage 2
    // ------------------------------------------------------------------
    logic [23:0] palette [PAL_N];

    // The lookup reads the registered entry, so a same-cycle pal_we to
    // that entry returns the old colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                palette[i] <= '0;
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
        end else begin
            rgb <= vis_q ? palette[idx_q] : '0;
        end
    end

endmodule

// File: tb/tb_ppu_line_mixer.sv
// tb_ppu_line_mixer
//   Directed self-checking bench for ppu_line_mixer. Expected colours and
//   flags are hand-derived constants. Sprite expectations follow
//   PPU_MIX_SPRITE_EN.
module tb_ppu_line_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic        vblank;
    logic        bg_we;
    logic [9:0]  bg_x;
    logic [2:0]  bg_idx;
    logic        spr_we;
    logic [9:0]  spr_x;
    logic [2:0]  spr_idx;
    logic        line_done;
    logic        pal_we;
    logic [2:0]  pal_addr;
    logic [23:0] pal_data;
    logic [23:0] rgb;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    localparam logic [23:0] C_RED   = 24'hFF0000;
    localparam logic [23:0] C_GREEN = 24'h00FF00;
    localparam logic [23:0] C_BLUE  = 24'h0000FF;
    localparam logic [23:0] C_NEW   = 24'h123456;
    localparam logic [10:0] H_IDLE  = 11'd1300;

`ifdef PPU_MIX_SPRITE_EN
    localparam logic [23:0] EXP_X7 = C_BLUE;
`else
    localparam logic [23:0] EXP_X7 = C_GREEN;
`endif

    ppu_line_mixer #(.LINE_W(640), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vblank    (vblank),
        .bg_we     (bg_we),
        .bg_x      (bg_x),
        .bg_idx    (bg_idx),
        .spr_we    (spr_we),
        .spr_x     (spr_x),
        .spr_idx   (spr_idx),
        .line_done (line_done),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .rgb       (rgb),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bg_write(input int x, input int idx);
        bg_we = 1'b1; bg_x = 10'(x); bg_idx = 3'(idx);
        tick();
        bg_we = 1'b0;
    endtask

    task automatic spr_write(input int x, input int idx);
        spr_we = 1'b1; spr_x = 10'(x); spr_idx = 3'(idx);
        tick();
        spr_we = 1'b0;
    endtask

    task automatic pal_write(input int a, input logic [23:0] d);
        pal_we = 1'b1; pal_addr = 3'(a); pal_data = d;
        tick();
        pal_we = 1'b0;
    endtask

    task automatic pulse_done();
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
    endtask

    task automatic line_start();
        hcount = '0;
        tick();
        hcount = H_IDLE;
    endtask

    // Present one hcount for a cycle, then check rgb after the second edge.
    task automatic pix_h(input int h, input logic vb, input logic [23:0] exp, input string tag);
        hcount = 11'(h); vblank = vb;
        tick();
        hcount = H_IDLE; vblank = 1'b0;
        tick();
        check(tag, rgb, exp);
    endtask

    initial begin
        reset = 1'b1; hcount = H_IDLE; vblank = 1'b0;
        bg_we = 1'b0; bg_x = '0; bg_idx = '0;
        spr_we = 1'b0; spr_x = '0; spr_idx = '0;
        line_done = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        tick(); tick();
        check("reset_rgb", rgb, 24'h0);
        check("reset_underrun", {23'h0, underrun}, 24'h0);
        reset = 1'b0;

        pal_write(1, C_GREEN);
        pal_write(2, C_RED);
        pal_write(3, C_BLUE);

        // Line start during vblank with nothing pending is not an underrun.
        vblank = 1'b1;
        line_start();
        vblank = 1'b0;
        check("vblank_no_underrun", {23'h0, underrun}, 24'h0);

        // Fill write bank (bank 1).
        bg_write(5, 2);
        bg_write(7, 1);
        spr_write(7, 3);
        bg_write(8, 1);
        spr_write(8, 3);
        spr_write(8, 0);
        bg_write(60, 1);
        bg_write(188, 1);
        bg_write(700, 3);
        pulse_done();
        line_start();
        check("swap1_underrun", {23'h0, underrun}, 24'h0);

        pix_h(10, 1'b0, C_RED, "x5_bg_red");
        pix_h(14, 1'b0, EXP_X7, "x7_sprite_overlay");
        pix_h(16, 1'b0, C_GREEN, "x8_transparent_sprite");
        pix_h(120, 1'b0, C_GREEN, "x60_after_oob_write");
        pix_h(376, 1'b0, C_GREEN, "x188_after_oob_write");
        pix_h(1300, 1'b0, 24'h0, "x650_out_of_line");
        pix_h(10, 1'b1, 24'h0, "vblank_blank");

        // Underrun: bank 0 gets new data but no line_done before the swap.
        bg_write(5, 3);
        line_start();
        check("underrun_set", {23'h0, underrun}, 24'h1);
        pix_h(10, 1'b0, C_RED, "underrun_repeat_line");

        pulse_done();
        line_start();
        check("underrun_sticky", {23'h0, underrun}, 24'h1);
        pix_h(10, 1'b0, C_BLUE, "late_line_swapped_in");

        // Back to bank 1: its sprite bits were cleared when it became the write bank.
        pulse_done();
        line_start();
        pix_h(14, 1'b0, C_GREEN, "x7_sprite_cleared");
        pix_h(10, 1'b0, C_RED, "x5_bg_kept");

        // line_done and bg_we in the swap cycle.
        pulse_done();
        hcount = '0; line_done = 1'b1;
        bg_we = 1'b1; bg_x = 10'd5; bg_idx = 3'd1;
        tick();
        hcount = H_IDLE; line_done = 1'b0; bg_we = 1'b0;
        check("swap_cycle_pending", {23'h0, dut.pending}, 24'h1);
        pix_h(10, 1'b0, C_GREEN, "swap_cycle_write_preswap");
        line_start();
        pix_h(10, 1'b0, C_RED, "pending_kept_swaps");
        line_start();
        pix_h(10, 1'b0, C_RED, "no_pending_no_swap");

        // Palette write hitting the entry being looked up returns old colour.
        hcount = 11'd10;
        tick();
        hcount = H_IDLE;
        pal_we = 1'b1; pal_addr = 3'd2; pal_data = C_NEW;
        tick();
        pal_we = 1'b0;
        check("pal_same_cycle_old", rgb, C_RED);
        pix_h(10, 1'b0, C_NEW, "pal_new_value");

        // Reset mid-line.
        hcount = 11'd10;
        tick();
        reset = 1'b1;
        tick();
        check("midreset_rgb", rgb, 24'h0);
        check("midreset_underrun", {23'h0, underrun}, 24'h0);
        check("midreset_bank", {23'h0, dut.display_bank}, 24'h0);
        check("midreset_pending", {23'h0, dut.pending}, 24'h0);
        reset = 1'b0;
        pix_h(10, 1'b0, 24'h0, "palette_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
